// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX register and its ALU control decode.
// Holds the ALU codes, funct values, alu_op classes and control bundle.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_OR    = 2'b11;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_alu_control_decode.sv
// Combinational alu_op/funct to 4-bit ALU control translation.
// Unsupported R-type funct falls back to add and raises illegal.
module alu_control_decode
  import id_ex_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    unique case (alu_op)
      OP_ADD: alu_ctrl = ALU_ADD;
      OP_SUB: alu_ctrl = ALU_SUB;
      OP_OR:  alu_ctrl = ALU_OR;
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_ctrl = ALU_ADD;
          F_SUB:   alu_ctrl = ALU_SUB;
          F_AND:   alu_ctrl = ALU_AND;
          F_OR:    alu_ctrl = ALU_OR;
          F_NOR:   alu_ctrl = ALU_NOR;
          F_SLT:   alu_ctrl = ALU_SLT;
          default: illegal  = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with EX/MEM and MEM/WB
// operand forwarding and a load-use stall request back to decode.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      valid_in,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [1:0]                alu_op,
  input  logic [5:0]                funct,
  input  logic [DATA_WIDTH-1:0]     read_data_0,
  input  logic [DATA_WIDTH-1:0]     read_data_1,
  input  logic [DATA_WIDTH-1:0]     sign_imm,
  input  logic                      alu_src,
  input  logic                      reg_dst,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rt,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      reg_write,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic                      mem_to_reg,
  input  logic                      ex_mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] ex_mem_dest,
  input  logic [DATA_WIDTH-1:0]     ex_mem_result,
  input  logic                      mem_wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_dest,
  input  logic [DATA_WIDTH-1:0]     mem_wb_result,
  output logic [DATA_WIDTH-1:0]     alu_data_in_0,
  output logic [DATA_WIDTH-1:0]     alu_data_in_1,
  output logic [3:0]                alu_control,
  output logic [DATA_WIDTH-1:0]     store_data,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic                      valid_out,
  output logic                      reg_write_out,
  output logic                      mem_read_out,
  output logic                      mem_write_out,
  output logic                      mem_to_reg_out,
  output logic                      illegal_funct,
  output logic                      load_use_stall
);

  localparam logic [REG_ADDR_WIDTH-1:0] R0 = '0;

  ctrl_t                     ctrl_d, ctrl_q;
  logic [3:0]                alu_ctrl_d, alu_ctrl_q;
  logic [REG_ADDR_WIDTH-1:0] rs_d, rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_d, rt_q;
  logic [REG_ADDR_WIDTH-1:0] wr_d, wr_q;
  logic [DATA_WIDTH-1:0]     rs_data_d, rs_data_q;
  logic [DATA_WIDTH-1:0]     rt_data_d, rt_data_q;
  logic [DATA_WIDTH-1:0]     imm_d, imm_q;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;

  alu_control_decode u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal)
  );

  always_comb begin
    ctrl_d     = ctrl_q;
    alu_ctrl_d = alu_ctrl_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    wr_d       = wr_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    // flush wins over stall; an empty decode slot loads as a bubble
    if (flush || (!stall && !valid_in)) begin
      ctrl_d     = '0;
      alu_ctrl_d = '0;
      rs_d       = '0;
      rt_d       = '0;
      wr_d       = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
    end else if (!stall) begin
      ctrl_d.valid      = 1'b1;
      ctrl_d.reg_write  = reg_write;
      ctrl_d.mem_read   = mem_read;
      ctrl_d.mem_write  = mem_write;
      ctrl_d.mem_to_reg = mem_to_reg;
      ctrl_d.alu_src    = alu_src;
      ctrl_d.illegal    = dec_illegal;
      alu_ctrl_d        = dec_ctrl;
      rs_d              = rs;
      rt_d              = rt;
      wr_d              = reg_dst ? rd : rt;
      rs_data_d         = read_data_0;
      rt_data_d         = read_data_1;
      imm_d             = sign_imm;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      alu_ctrl_q <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wr_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= alu_ctrl_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      wr_q       <= wr_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
    end
  end

  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a = rs_data_q;
    if (ex_mem_reg_write && ex_mem_dest != R0 && ex_mem_dest == rs_q)
      fwd_a = ex_mem_result;
    else if (mem_wb_reg_write && mem_wb_dest != R0 && mem_wb_dest == rs_q)
      fwd_a = mem_wb_result;
  end

  always_comb begin
    fwd_b = rt_data_q;
    if (ex_mem_reg_write && ex_mem_dest != R0 && ex_mem_dest == rt_q)
      fwd_b = ex_mem_result;
    else if (mem_wb_reg_write && mem_wb_dest != R0 && mem_wb_dest == rt_q)
      fwd_b = mem_wb_result;
  end

  assign alu_data_in_0  = fwd_a;
  assign alu_data_in_1  = ctrl_q.alu_src ? imm_q : fwd_b;
  assign store_data     = fwd_b;
  assign alu_control    = alu_ctrl_q;
  assign write_reg      = wr_q;
  assign valid_out      = ctrl_q.valid;
  assign reg_write_out  = ctrl_q.reg_write;
  assign mem_read_out   = ctrl_q.mem_read;
  assign mem_write_out  = ctrl_q.mem_write;
  assign mem_to_reg_out = ctrl_q.mem_to_reg;
  assign illegal_funct  = ctrl_q.illegal;

  assign load_use_stall = ctrl_q.valid & ctrl_q.mem_read & (wr_q != R0)
                        & ((wr_q == rs) | (wr_q == rt));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, decode, forwarding,
// load-use detection, stall/flush and asynchronous reset.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_in, stall, flush;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] read_data_0, read_data_1, sign_imm;
  logic        alu_src, reg_dst;
  logic [4:0]  rs, rt, rd;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_dest;
  logic [31:0] ex_mem_result;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_result;
  logic [31:0] alu_data_in_0, alu_data_in_1, store_data;
  logic [3:0]  alu_control;
  logic [4:0]  write_reg;
  logic        valid_out, reg_write_out, mem_read_out;
  logic        mem_write_out, mem_to_reg_out;
  logic        illegal_funct, load_use_stall;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .valid_in         (valid_in),
    .stall            (stall),
    .flush            (flush),
    .alu_op           (alu_op),
    .funct            (funct),
    .read_data_0      (read_data_0),
    .read_data_1      (read_data_1),
    .sign_imm         (sign_imm),
    .alu_src          (alu_src),
    .reg_dst          (reg_dst),
    .rs               (rs),
    .rt               (rt),
    .rd               (rd),
    .reg_write        (reg_write),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_to_reg       (mem_to_reg),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_dest      (ex_mem_dest),
    .ex_mem_result    (ex_mem_result),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_dest      (mem_wb_dest),
    .mem_wb_result    (mem_wb_result),
    .alu_data_in_0    (alu_data_in_0),
    .alu_data_in_1    (alu_data_in_1),
    .alu_control      (alu_control),
    .store_data       (store_data),
    .write_reg        (write_reg),
    .valid_out        (valid_out),
    .reg_write_out    (reg_write_out),
    .mem_read_out     (mem_read_out),
    .mem_write_out    (mem_write_out),
    .mem_to_reg_out   (mem_to_reg_out),
    .illegal_funct    (illegal_funct),
    .load_use_stall   (load_use_stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; stall = 0; flush = 0;
    alu_op = 2'b00; funct = 6'b0;
    read_data_0 = 0; read_data_1 = 0; sign_imm = 0;
    alu_src = 0; reg_dst = 0;
    rs = 0; rt = 0; rd = 0;
    reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    ex_mem_reg_write = 0; ex_mem_dest = 0; ex_mem_result = 0;
    mem_wb_reg_write = 0; mem_wb_dest = 0; mem_wb_result = 0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    #2;
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_aluctl", {28'b0, alu_control}, 32'h0);
    chk("rst_wreg", {27'b0, write_reg}, 32'h0);
    chk("rst_opa", alu_data_in_0, 32'h0);
    chk("rst_illegal", {31'b0, illegal_funct}, 32'h0);
    @(negedge clock);
    reset_n = 1;

    // R-type sub, rd destination
    valid_in = 1; alu_op = 2'b10; funct = 6'b100010;
    read_data_0 = 7; read_data_1 = 3;
    rs = 1; rt = 2; rd = 3; reg_dst = 1; reg_write = 1;
    step();
    chk("sub_ctl", {28'b0, alu_control}, 32'h6);
    chk("sub_a", alu_data_in_0, 32'd7);
    chk("sub_b", alu_data_in_1, 32'd3);
    chk("sub_wreg", {27'b0, write_reg}, 32'd3);
    chk("sub_valid", {31'b0, valid_out}, 32'h1);
    chk("sub_illegal", {31'b0, illegal_funct}, 32'h0);

    // forwarding priority and register-zero exclusion
    alu_op = 2'b00; rs = 5; rt = 6;
    read_data_0 = 32'h11; read_data_1 = 32'h22;
    ex_mem_reg_write = 1; ex_mem_dest = 5; ex_mem_result = 32'hDEADBEEF;
    mem_wb_reg_write = 1; mem_wb_dest = 5; mem_wb_result = 32'h1;
    step();
    chk("fwd_exmem", alu_data_in_0, 32'hDEADBEEF);
    chk("fwd_b_none", alu_data_in_1, 32'h22);
    ex_mem_dest = 0;
    #1;
    chk("fwd_memwb", alu_data_in_0, 32'h1);
    mem_wb_dest = 0;
    #1;
    chk("fwd_r0", alu_data_in_0, 32'h11);
    mem_wb_dest = 6; mem_wb_result = 32'h77;
    #1;
    chk("fwd_b_memwb", alu_data_in_1, 32'h77);
    chk("fwd_store", store_data, 32'h77);

    // immediate operand; store_data still the forwarded rt
    alu_src = 1; sign_imm = 32'hFFFFFFFC; alu_op = 2'b00;
    ex_mem_reg_write = 0; mem_wb_dest = 6; mem_wb_result = 32'h99;
    step();
    chk("imm_b", alu_data_in_1, 32'hFFFFFFFC);
    chk("imm_ctl", {28'b0, alu_control}, 32'h2);
    chk("imm_store", store_data, 32'h99);

    // other decodes
    alu_src = 0; alu_op = 2'b11;
    step();
    chk("op11_ctl", {28'b0, alu_control}, 32'h1);
    alu_op = 2'b10; funct = 6'b101010;
    step();
    chk("slt_ctl", {28'b0, alu_control}, 32'h7);
    funct = 6'b100111;
    step();
    chk("nor_ctl", {28'b0, alu_control}, 32'hC);

    // load word to rt=8, then load-use detection
    mem_wb_reg_write = 0;
    alu_op = 2'b00; alu_src = 1; reg_dst = 0; rt = 8; rd = 4;
    mem_read = 1; mem_to_reg = 1; rs = 1;
    step();
    chk("lw_wreg", {27'b0, write_reg}, 32'd8);
    chk("lw_mrd", {31'b0, mem_read_out}, 32'h1);
    rs = 8; rt = 9; mem_read = 0; mem_to_reg = 0;
    #1;
    chk("lu_rs", {31'b0, load_use_stall}, 32'h1);
    rs = 10; rt = 8;
    #1;
    chk("lu_rt", {31'b0, load_use_stall}, 32'h1);
    rs = 10; rt = 11;
    #1;
    chk("lu_none", {31'b0, load_use_stall}, 32'h0);
    rs = 8;
    stall = 1; flush = 1;
    step();
    chk("fl_valid", {31'b0, valid_out}, 32'h0);
    chk("fl_mrd", {31'b0, mem_read_out}, 32'h0);
    chk("fl_lu", {31'b0, load_use_stall}, 32'h0);

    // illegal funct, then hold under stall
    stall = 0; flush = 0;
    alu_op = 2'b10; funct = 6'b000000; alu_src = 0;
    rs = 2; rt = 3; read_data_0 = 32'h55; read_data_1 = 32'h66;
    step();
    chk("ill_flag", {31'b0, illegal_funct}, 32'h1);
    chk("ill_ctl", {28'b0, alu_control}, 32'h2);
    stall = 1; alu_op = 2'b01; read_data_0 = 32'hAA; valid_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ill", {31'b0, illegal_funct}, 32'h1);
      chk("hold_ctl", {28'b0, alu_control}, 32'h2);
      chk("hold_a", alu_data_in_0, 32'h55);
      chk("hold_valid", {31'b0, valid_out}, 32'h1);
    end

    // empty decode slot loads a bubble
    stall = 0;
    step();
    chk("bub_valid", {31'b0, valid_out}, 32'h0);
    chk("bub_ill", {31'b0, illegal_funct}, 32'h0);
    chk("bub_regw", {31'b0, reg_write_out}, 32'h0);

    // asynchronous reset between edges
    valid_in = 1; alu_op = 2'b10; funct = 6'b100101; reg_write = 1;
    step();
    chk("or_ctl", {28'b0, alu_control}, 32'h1);
    chk("pre_rst_valid", {31'b0, valid_out}, 32'h1);
    reset_n = 0;
    #1;
    chk("arst_valid", {31'b0, valid_out}, 32'h0);
    chk("arst_regw", {31'b0, reg_write_out}, 32'h0);
    chk("arst_ctl", {28'b0, alu_control}, 32'h0);
    @(negedge clock);
    reset_n = 1;
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the 32-bit ALU.
- Captures decoded operands and control each cycle and translates alu_op/funct into the 4-bit ALU control code.
- Resolves EX operands through EX/MEM and MEM/WB forwarding, then drives the ALU's two data inputs and its control input.
- Raises a load-use stall request back to decode.

Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, register specifier width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- valid_in  in  1  decode slot holds a real instruction
- stall  in  1  hold current contents
- flush  in  1  replace contents with bubble
- alu_op  in  2  main-control ALU class
- funct  in  6  R-type function field
- read_data_0  in  32  rs register value
- read_data_1  in  32  rt register value
- sign_imm  in  32  sign-extended immediate
- alu_src  in  1  1 = immediate drives operand 1
- reg_dst  in  1  1 = rd is destination, 0 = rt
- rs, rt, rd  in  5 each  register specifiers
- reg_write, mem_read, mem_write, mem_to_reg  in  1 each  downstream control
- ex_mem_reg_write  in  1  EX/MEM forwarding source enable
- ex_mem_dest  in  5  EX/MEM forwarding source register
- ex_mem_result  in  32  EX/MEM forwarding source value
- mem_wb_reg_write  in  1  MEM/WB forwarding source enable
- mem_wb_dest  in  5  MEM/WB forwarding source register
- mem_wb_result  in  32  MEM/WB forwarding source value
- alu_data_in_0, alu_data_in_1  out  32 each  ALU operands
- alu_control  out  4  ALU operation
- store_data  out  32  forwarded rt for stores
- write_reg  out  5  destination register
- valid_out, reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out  out  1 each  registered control
- illegal_funct  out  1  registered: R-type funct unsupported
- load_use_stall  out  1  combinational request to decode

Behaviour:
- Reset (async, reset_n low): every register cleared. Therefore valid_out = 0, all control outputs = 0, write_reg = 0, illegal_funct = 0, alu_control = 4'b0000, operand and immediate registers = 0.
- Clock-edge update rules:
  - flush = 1: load a bubble (valid and all control bits cleared; data fields don't-care, cleared). flush takes priority over stall.
  - stall = 1, flush = 0: hold all registers.
  - Otherwise: load all inputs. Destination is captured as write_reg = reg_dst ? rd : rt.
  - valid_in = 0 on load: same effect as flush.
- ALU control decode happens at capture and is registered, so latency is 1 cycle:
  - alu_op 00 → 0010 (add)
  - alu_op 01 → 0110 (sub)
  - alu_op 11 → 0001 (or)
  - alu_op 10 → from funct: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 100111 → 1100, 101010 → 0111.
  - Any other funct → 0010 with illegal_funct = 1. illegal_funct is only ever set when alu_op = 10 and valid_in = 1.
- Forwarding (combinational, operand A; operand B identical using rt_q):
  - If ex_mem_reg_write, ex_mem_dest != 0 and ex_mem_dest == rs_q → ex_mem_result.
  - Else if mem_wb_reg_write, mem_wb_dest != 0 and mem_wb_dest == rs_q → mem_wb_result.
  - Else → rs_data_q.
  - EX/MEM beats MEM/WB when both match. Register 0 is never forwarded.
- Operand outputs:
  - store_data = forwarded B.
  - alu_data_in_1 = alu_src_q ? imm_q : forwarded B.
  - alu_data_in_0 = forwarded A.
- load_use_stall = valid_out & mem_read_out & (write_reg != 0) & (write_reg == rs | write_reg == rt), compared against the decode-stage rs/rt inputs. Decode must respond by asserting stall upstream and flush here.
- Reset mid-operation clears immediately, without waiting for a clock edge.

Decomposition:
- Shared package: ALU control code constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100), funct constants, alu_op encodings, and a packed struct for the registered control bundle.
- One sub-module: alu_control_decode (combinational alu_op/funct → code plus illegal flag), reused by the pipeline-register wrapper.

Test Plan:
- Load R-type funct 100010, rs data 7, rt data 3, no forwarding → next cycle alu_control = 0110, alu_data_in_0 = 7, alu_data_in_1 = 3.
- ex_mem_dest = rs_q = 5, ex_mem_reg_write = 1, ex_mem_result = 0xDEADBEEF, mem_wb_dest = 5 with 0x1 → alu_data_in_0 = 0xDEADBEEF; same case with dest 0 → register value passes through.
- alu_src = 1, sign_imm = 0xFFFFFFFC, alu_op = 00 → alu_data_in_1 = 0xFFFFFFFC, alu_control = 0010; store_data still equals forwarded rt.
- Captured lw to rt = 8, decode presents rs = 8 → load_use_stall = 1; with stall and flush both asserted for one edge → valid_out = 0, mem_read_out = 0.
- alu_op = 10, funct = 000000 → illegal_funct = 1, alu_control = 0010; stall held 3 cycles → outputs unchanged throughout.
- reset_n pulsed low between edges while valid_out = 1 → valid_out, reg_write_out and alu_control drop to 0 immediately, with no clock edge.
